// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blitter: FSM states, screen defaults,
// the transparency key and the generator for the sprite image data.
package sprite_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_e;

  localparam int DEF_X_MAX       = 160;
  localparam int DEF_Y_MAX       = 120;
  localparam int TRANSPARENT_KEY = 0;

  // Image data generator; the ROM truncates the result to its colour width.
  function automatic int rom_word(input int addr);
    return 5 * addr + 1;
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous sprite ROM holding every direction frame back-to-back, one-cycle read latency.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int DEPTH = 100,
  parameter int AW    = 7,
  parameter int CW    = 3
) (
  input  logic          clock,
  input  logic [AW-1:0] addr_i,
  output logic [CW-1:0] data_o
);

  logic [CW-1:0] mem [DEPTH];
  logic [CW-1:0] data_q;

  // Contents are elaborated from the package generator, so the array is constant.
  for (genvar i = 0; i < DEPTH; i++) begin : g_init
    assign mem[i] = CW'(rom_word(i));
  end

  always_ff @(posedge clock) data_q <= mem[addr_i];

  assign data_o = data_q;

endmodule

// File: rtl/sprite_blit.sv
// Sprite blitter: walks a SPR_W x SPR_H frame, emitting clipped, ROM-aligned pixel writes.
// Optional build macro SPRITE_TRANSPARENCY_EN suppresses pixels whose ROM colour is the key.
module sprite_blit
  import sprite_pkg::*;
#(
  parameter int SPR_W     = 5,
  parameter int SPR_H     = 5,
  parameter int NUM_DIR   = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOUR_W  = 3,
  parameter int X_MAX     = DEF_X_MAX,
  parameter int Y_MAX     = DEF_Y_MAX,
  parameter int BG_COLOUR = 0,
  localparam int DIR_W    = (NUM_DIR > 1) ? $clog2(NUM_DIR) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [DIR_W-1:0]    dir,
  input  logic                erase,
  input  logic [X_W-1:0]      startx,
  input  logic [Y_W-1:0]      starty,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int N    = SPR_W * SPR_H;
  localparam int DEPTH = NUM_DIR * N;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW   = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int XEW  = X_W + 1;
  localparam int YEW  = Y_W + 1;

  state_e              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic [DIR_W-1:0]    dir_q;
  logic                erase_q;
  logic [X_W-1:0]      sx_q;
  logic [Y_W-1:0]      sy_q;
  logic                issue;

  // Stage 1 carries the pixel position alongside the outstanding ROM read.
  logic                s1_vld_q, s1_inb_q;
  logic [X_W-1:0]      s1_x_q, x_q;
  logic [Y_W-1:0]      s1_y_q, y_q;
  logic [COLOUR_W-1:0] colour_q, colour_d, rom_data;
  logic                plot_q, plot_d, busy_q, done_q, transp;

  logic [AW-1:0]       rom_addr;
  logic [XEW-1:0]      xe;
  logic [YEW-1:0]      ye;
  logic                inb;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = DRAW;
        col_d   = '0;
        row_d   = '0;
      end
      DRAW: begin
        issue = 1'b1;
        if (col_q == CW'(SPR_W - 1)) begin
          col_d = '0;
          if (row_q == RW'(SPR_H - 1)) state_d = FLUSH;
          else                          row_d   = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rom_addr = AW'(int'(dir_q) * N + int'(row_q) * SPR_W + int'(col_q));
  // Clip on the untruncated coordinate so wrap-around never lands on screen.
  assign xe  = XEW'(sx_q) + XEW'(col_q);
  assign ye  = YEW'(sy_q) + YEW'(row_q);
  assign inb = (xe < XEW'(X_MAX)) && (ye < YEW'(Y_MAX));

  sprite_rom #(.DEPTH(DEPTH), .AW(AW), .CW(COLOUR_W)) u_rom (
    .clock  (clock),
    .addr_i (rom_addr),
    .data_o (rom_data)
  );

`ifdef SPRITE_TRANSPARENCY_EN
  assign transp = !erase_q && (rom_data == COLOUR_W'(TRANSPARENT_KEY));
`else
  assign transp = 1'b0;
`endif

  assign colour_d = erase_q ? COLOUR_W'(BG_COLOUR) : rom_data;
  assign plot_d   = s1_vld_q && s1_inb_q && !transp;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      dir_q    <= '0;
      erase_q  <= 1'b0;
      sx_q     <= '0;
      sy_q     <= '0;
      s1_vld_q <= 1'b0;
      s1_inb_q <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (state_q == IDLE && start) begin
        dir_q   <= dir;
        erase_q <= erase;
        sx_q    <= startx;
        sy_q    <= starty;
      end
      s1_vld_q <= issue;
      s1_inb_q <= inb;
      s1_x_q   <= xe[X_W-1:0];
      s1_y_q   <= ye[Y_W-1:0];
      x_q      <= s1_x_q;
      y_q      <= s1_y_q;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= (state_q == DONE);
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sprite_blit.sv
// Scoreboard bench for sprite_blit: draws push expected pixels/done cycles, a negedge monitor checks them.
module tb_sprite_blit;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dir   = '0;
  logic       erase = 1'b0;
  logic [7:0] startx = '0;
  logic [6:0] starty = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  sprite_blit dut (
    .clock(clock), .reset(reset), .start(start), .dir(dir), .erase(erase),
    .startx(startx), .starty(starty), .x(x), .y(y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct { int cyc; int x; int y; int c; } pix_t;
  pix_t exp_q[$];
  int   done_exp[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Hand model: raster walk, ROM word = (5*addr+1) mod 8, screen 160x120.
  task automatic push_draw(input int e, input int d, input int er, input int sx, input int sy,
                           input int limit, input bit with_done);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        int idx, addr, col, xe, ye;
        bit vis;
        pix_t p;
        idx  = r * 5 + c;
        addr = d * 25 + idx;
        col  = er ? 0 : (5 * addr + 1) % 8;
        xe   = sx + c;
        ye   = sy + r;
        vis  = (idx < limit) && (xe < 160) && (ye < 120);
`ifdef SPRITE_TRANSPARENCY_EN
        if (!er && col == 0) vis = 1'b0;
`endif
        if (vis) begin
          p.cyc = e + 2 + idx; p.x = xe % 256; p.y = ye % 128; p.c = col;
          exp_q.push_back(p);
        end
      end
    if (with_done) done_exp.push_back(e + 27);
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      if (plot) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_plot at cycle %0d x %0d y %0d colour %0d", cyc, x, y, colour);
        end else begin
          pix_t p;
          p = exp_q.pop_front();
          chk("plot_cycle", cyc, p.cyc);
          chk("plot_x", int'(x), p.x);
          chk("plot_y", int'(y), p.y);
          chk("plot_colour", int'(colour), p.c);
        end
      end
      if (done) begin
        if (done_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          chk("done_cycle", cyc, done_exp.pop_front());
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  task automatic start_draw(input int d, input int er, input int sx, input int sy, output int e);
    @(negedge clock);
    dir = 2'(d); erase = er[0]; startx = 8'(sx); starty = 7'(sy); start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    e = cyc;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL wait_idle_timeout actual busy %0d required 0", busy);
    end
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int e;
    repeat (3) @(negedge clock);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clock);

    // Basic frame 0 draw; includes ROM words of colour 0 (addr 3, 11, 19).
    start_draw(0, 0, 10, 20, e);
    push_draw(e, 0, 0, 10, 20, 25, 1'b1);
    wait_idle();

    // Last frame, then the same frame erased.
    start_draw(3, 0, 40, 60, e);
    push_draw(e, 3, 0, 40, 60, 25, 1'b1);
    wait_idle();
    start_draw(3, 1, 10, 20, e);
    push_draw(e, 3, 1, 10, 20, 25, 1'b1);
    wait_idle();

    // Clipping at the bottom-right corner.
    start_draw(1, 0, 158, 118, e);
    push_draw(e, 1, 0, 158, 118, 25, 1'b1);
    wait_idle();

    // A second start mid-draw with different inputs must be ignored.
    start_draw(2, 0, 100, 5, e);
    push_draw(e, 2, 0, 100, 5, 25, 1'b1);
    repeat (4) @(negedge clock);
    dir = 2'd1; erase = 1'b1; startx = 8'd50; starty = 7'd50; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();

    // Reset sampled at edge T+10 aborts the draw after 8 pixels.
    start_draw(0, 0, 30, 40, e);
    push_draw(e, 0, 0, 30, 40, 8, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_plot", int'(plot), 0);
    chk("abort_busy", int'(busy), 0);
    reset = 1'b1;
    repeat (40) @(negedge clock);

    // Normal draw after the abort.
    start_draw(2, 0, 0, 0, e);
    push_draw(e, 2, 0, 0, 0, 25, 1'b1);
    wait_idle();

    chk("pixels_left", exp_q.size(), 0);
    chk("dones_left", done_exp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
